// File: rtl/ladder_lpf_sched.sv
// Four-pole ladder low-pass, one shared multiplier time-sliced over
// N_CH channels: feedback term then four stages per channel, one op per clk.
module ladder_lpf_sched #(
  parameter int W    = 16,
  parameter int N_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic [N_CH*W-1:0] sample_in,
  input  logic [W-1:0]      g,
  input  logic [W-1:0]      resonance,
  output logic [N_CH*W-1:0] sample_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = 2*W + 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FB   = 3'd1;
  localparam logic [2:0] S1   = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] S3   = 3'd4;
  localparam logic [2:0] S4   = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam logic signed [PW-1:0] HI =
    {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] LO =
    {{(W+3){1'b1}}, {(W-1){1'b0}}};

  logic [2:0]          state;
  logic [CW-1:0]       ch;
  logic                prev;
  logic                strobe;
  logic signed [W-1:0] in_lat [N_CH];
  logic [W-1:0]        g_lat;
  logic [W-1:0]        res_lat;
  logic signed [W-1:0] st [N_CH][4];
  logic signed [W-1:0] x_r;

  logic [1:0]           k;
  logic signed [W-1:0]  cur;
  logic signed [W-1:0]  prv;
  logic signed [W:0]    diff;
  logic signed [PW-1:0] op_a;
  logic signed [PW-1:0] op_b;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] fb_sh;
  logic signed [PW-1:0] dk_sh;
  logic signed [PW-1:0] in_wide;
  logic signed [PW-1:0] cur_wide;
  logic signed [PW-1:0] x_wide;
  logic signed [PW-1:0] a_wide;
  logic signed [W-1:0]  x_next;
  logic signed [W-1:0]  a_next;

  function automatic logic signed [W-1:0] sat(
    input logic signed [PW-1:0] v
  );
    if (v > HI) return {1'b0, {(W-1){1'b1}}};
    if (v < LO) return {1'b1, {(W-1){1'b0}}};
    return v[W-1:0];
  endfunction

  assign strobe = sample_clk & ~prev;
  assign busy   = (state != IDLE);

  always_comb begin
    k = 2'd0;
    unique case (1'b1)
      (state == S2): k = 2'd1;
      (state == S3): k = 2'd2;
      (state == S4): k = 2'd3;
      default:       k = 2'd0;
    endcase
  end

  // Intermediates are full product width so nothing can wrap before sat().
  always_comb begin
    cur  = st[ch][k];
    prv  = (state == S1) ? x_r : st[ch][k - 2'd1];
    diff = {prv[W-1], prv} - {cur[W-1], cur};
    if (state == FB) begin
      op_a = {{(W+2){st[ch][3][W-1]}}, st[ch][3]};
      op_b = {{(W+2){1'b0}}, res_lat};
    end else begin
      op_a = {{(W+1){diff[W]}}, diff};
      op_b = {{(W+2){1'b0}}, g_lat};
    end
    prod     = op_a * op_b;
    fb_sh    = prod >>> 13;
    dk_sh    = prod >>> 15;
    in_wide  = {{(W+2){in_lat[ch][W-1]}}, in_lat[ch]};
    cur_wide = {{(W+2){cur[W-1]}}, cur};
    x_wide   = in_wide - fb_sh;
    a_wide   = cur_wide + dk_sh;
    x_next   = sat(x_wide);
    a_next   = sat(a_wide);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      prev       <= 1'b1;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      sample_out <= '0;
      x_r        <= '0;
      g_lat      <= '0;
      res_lat    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        in_lat[c] <= '0;
        for (int j = 0; j < 4; j++) st[c][j] <= '0;
      end
    end else begin
      prev      <= sample_clk;
      out_valid <= 1'b0;
      if (strobe && busy) overrun <= 1'b1;
      unique case (state)
        IDLE: if (strobe) begin
          for (int c = 0; c < N_CH; c++)
            in_lat[c] <= sample_in[c*W +: W];
          g_lat   <= g;
          res_lat <= resonance;
          ch      <= '0;
          state   <= FB;
        end
        FB: begin
          x_r   <= x_next;
          state <= S1;
        end
        S1, S2, S3: begin
          st[ch][k] <= a_next;
          state     <= state + 3'd1;
        end
        S4: begin
          st[ch][k] <= a_next;
          if (ch == CW'(N_CH - 1)) begin
            state <= DONE;
          end else begin
            ch    <= ch + CW'(1);
            state <= FB;
          end
        end
        DONE: begin
          for (int c = 0; c < N_CH; c++)
            sample_out[c*W +: W] <= st[c][3];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ladder_lpf_sched.sv
// Bench for ladder_lpf_sched: per-cycle compare against an
// arithmetic reference model, plus directed scenarios with literal pins.
module tb_ladder_lpf_sched;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 5*N + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sample_clk = 1'b0;
  logic [N*W-1:0] sample_in = '0;
  logic [W-1:0]   g = '0;
  logic [W-1:0]   resonance = '0;
  logic [N*W-1:0] sample_out;
  logic           out_valid;
  logic           busy;
  logic           overrun;

  ladder_lpf_sched #(.W(W), .N_CH(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .sample_in  (sample_in),
    .g          (g),
    .resonance  (resonance),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 0;

  longint m_a [N][4];
  longint m_in [N];
  longint m_out [N];
  longint m_g, m_res;
  int     m_rem;
  bit     m_prev, m_ovr, m_valid, m_stb;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint dout(input int c);
    return longint'($signed(sample_out[c*W +: W]));
  endfunction

  // Whole filter pass in plain arithmetic; >>> on longint is floor.
  function automatic void run_pass();
    longint fb, p;
    for (int c = 0; c < N; c++) begin
      fb = (m_a[c][3] * m_res) >>> 13;
      p  = clamp(m_in[c] - fb);
      for (int s = 0; s < 4; s++) begin
        m_a[c][s] = clamp(m_a[c][s] + (((p - m_a[c][s]) * m_g) >>> 15));
        p = m_a[c][s];
      end
      m_out[c] = m_a[c][3];
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_prev = 1; m_ovr = 0; m_valid = 0;
      for (int c = 0; c < N; c++) begin
        m_out[c] = 0;
        for (int s = 0; s < 4; s++) m_a[c][s] = 0;
      end
    end else begin
      m_stb   = sample_clk && !m_prev;
      m_prev  = sample_clk;
      m_valid = 0;
      if (m_rem > 0) begin
        if (m_stb) m_ovr = 1;
        m_rem--;
        if (m_rem == 0) begin
          run_pass();
          m_valid = 1;
        end
      end else if (m_stb) begin
        for (int c = 0; c < N; c++)
          m_in[c] = longint'($signed(sample_in[c*W +: W]));
        m_g   = longint'(g);
        m_res = longint'(resonance);
        m_rem = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", longint'(out_valid), longint'(m_valid));
      chk("busy", longint'(busy), longint'(m_rem > 0));
      chk("overrun", longint'(overrun), longint'(m_ovr));
      for (int c = 0; c < N; c++)
        chk($sformatf("sample_out[%0d]", c), dout(c), m_out[c]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sample_clk = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    started = 1;
  endtask

  // Raises sample_clk now (caller sits on a negedge) and waits for out_valid.
  task automatic pass(input int hold, output int lat);
    int cyc;
    cyc = 0;
    lat = -1;
    sample_clk = 1'b1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) sample_clk = 1'b0;
      if (out_valid === 1'b1) begin
        lat = cyc - 1;
        break;
      end
    end
    sample_clk = 1'b0;
    if (lat < 0) chk("pass_timeout", 0, 1);
    else chk("latency", lat, LAT);
  endtask

  task automatic count_valid(input int n, output int nv);
    nv = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid === 1'b1) nv++;
    end
  endtask

  initial begin
    int lat, nv;
    do_reset();
    chk("rst_out0", dout(0), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovr", longint'(overrun), 0);

    // step response, then g=0 must hold the state
    g = 16'h4000; resonance = 16'h0000;
    sample_in = '0; sample_in[15:0] = 16'h4000;
    tick(2);
    pass(2, lat);
    chk("step1_ch0", dout(0), 1024);
    chk("step1_model", m_out[0], 1024);
    chk("step1_ch1", dout(1), 0);
    tick(3);
    pass(2, lat);
    chk("step2_ch0", dout(0), 3072);
    chk("step2_model", m_out[0], 3072);
    chk("step2_ch3", dout(3), 0);
    g = 16'h0000;
    tick(3);
    pass(2, lat);
    chk("g0_hold", dout(0), 3072);

    // floor rounding
    do_reset();
    g = 16'h4000; sample_in = '0; sample_in[15:0] = 16'h0001;
    tick(1);
    pass(2, lat);
    chk("floor_pos", dout(0), 0);
    do_reset();
    sample_in[15:0] = 16'hFFFF;
    tick(1);
    pass(2, lat);
    chk("floor_neg", dout(0), -1);
    chk("floor_neg_a1", m_a[0][0], -1);

    // overrun: second rising edge three cycles after the first
    do_reset();
    sample_in = '0; sample_in[15:0] = 16'h4000;
    tick(1);
    sample_clk = 1'b1; tick(1);
    sample_clk = 1'b0; tick(2);
    sample_clk = 1'b1; tick(1);
    sample_clk = 1'b0;
    count_valid(40, nv);
    chk("ovr_one_valid", nv, 1);
    chk("ovr_flag", longint'(overrun), 1);
    chk("ovr_out", dout(0), 1024);
    pass(2, lat);
    chk("ovr_clean", dout(0), 3072);
    chk("ovr_sticky", longint'(overrun), 1);

    // strobe landing in the out_valid cycle
    do_reset();
    tick(1);
    pass(2, lat);
    pass(2, lat);
    chk("b2b_ovr", longint'(overrun), 0);
    chk("b2b_out", dout(0), 3072);

    // reset seven cycles into a pass, sample_clk held high
    do_reset();
    tick(1);
    pass(2, lat);
    tick(2);
    sample_clk = 1'b1;
    tick(7);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    count_valid(40, nv);
    chk("midrst_no_valid", nv, 0);
    chk("midrst_out", dout(0), 0);
    chk("midrst_busy", longint'(busy), 0);
    sample_clk = 1'b0;
    tick(2);
    pass(2, lat);
    chk("midrst_restart", dout(0), 1024);

    // full-scale drive with resonance 4.0: loop rings between the rails
    do_reset();
    g = 16'h7FFF; resonance = 16'h8000;
    sample_in = '0;
    sample_in[15:0]  = 16'h7FFF;
    sample_in[31:16] = 16'h8000;
    sample_in[47:32] = 16'h4000;
    tick(1);
    for (int i = 0; i < 200; i++) begin
      pass(2, lat);
      if (i == 0) begin
        chk("sat_p1_ch0", dout(0), 32763);
        chk("sat_p1_ch1", dout(1), -32767);
      end
      if (i == 1) chk("sat_p2_ch0", dout(0), -32764);
      tick(1);
    end

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
